// File: rtl/half_duplex_pad_ctrl.sv
// half_duplex_pad_ctrl: drives a WIDTH-bit frame MSB first onto a shared pad, turns the bus around, optionally samples a WIDTH-bit reply.
// Latency: WIDTH*DIV drive + TURN turnaround cycles, plus (WIDTH-1)*DIV + DIV/2 + 1 sample cycles on reads; rx_valid lands in the following IDLE cycle.
// Backpressure: tx_ready only in IDLE, tx_valid is ignored elsewhere; rx_valid is a one-cycle pulse with no ready.
// Ports: CLK, RST (synchronous, active-high); tx_valid/tx_ready/tx_data/tx_read request side; rx_valid/rx_data reply side;
//        PAD_O/PAD_T/PAD_I to the tristate pad buffer (PAD_T=1 is high-Z); busy is high whenever the FSM is not IDLE.
module half_duplex_pad_ctrl #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4,
  parameter int TURN  = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_read,
  output logic             rx_valid,
  output logic [WIDTH-1:0] rx_data,
  output logic             PAD_O,
  output logic             PAD_T,
  input  logic             PAD_I,
  output logic             busy
);

  // One divider counter serves both the bit period and the turnaround.
  localparam int DMAX = (DIV > TURN) ? DIV : TURN;
  localparam int CW   = (DMAX > 1) ? $clog2(DMAX) : 1;
  localparam int BW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] TURN_LAST = CW'(TURN - 1);
  localparam logic [CW-1:0] SAMP_IDX  = CW'(DIV / 2);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_TURN,
    ST_SAMPLE
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    div_cnt, div_nxt;
  logic [BW-1:0]    bit_cnt, bit_nxt;
  logic [WIDTH-1:0] shreg, sh_nxt;
  logic             rd, rd_nxt;
  logic             rx_fire;

  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt + 1'b1;
    bit_nxt   = bit_cnt;
    sh_nxt    = shreg;
    rd_nxt    = rd;
    rx_fire   = 1'b0;

    case (state)
      ST_IDLE: begin
        div_nxt = '0;
        if (tx_valid) begin
          state_nxt = ST_DRIVE;
          sh_nxt    = tx_data;
          rd_nxt    = tx_read;
        end
      end

      ST_DRIVE: begin
        if (div_cnt == DIV_LAST) begin
          div_nxt = '0;
          if (bit_cnt == BIT_LAST) begin
            state_nxt = ST_TURN;
          end else begin
            bit_nxt = bit_cnt + 1'b1;
            sh_nxt  = shreg << 1;
          end
        end
      end

      ST_TURN: begin
        if (div_cnt == TURN_LAST) begin
          state_nxt = rd ? ST_SAMPLE : ST_IDLE;
        end
      end

      ST_SAMPLE: begin
        // The frame ends on the last sample edge, not at the end of the last
        // bit period, so the reply is visible as early as possible.
        if (div_cnt == SAMP_IDX) begin
          sh_nxt = (shreg << 1) | WIDTH'(PAD_I);
          if (bit_cnt == BIT_LAST) begin
            state_nxt = ST_IDLE;
            rx_fire   = 1'b1;
          end
        end
        if (div_cnt == DIV_LAST) begin
          div_nxt = '0;
          bit_nxt = bit_cnt + 1'b1;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // Every state starts counting from zero.
    if (state_nxt != state) begin
      div_nxt = '0;
      bit_nxt = '0;
    end
  end

  // Pad controls are registered from the next state, so PAD_T is low exactly
  // in the cycles where the registered state is DRIVE and nowhere else.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      rd       <= 1'b0;
      PAD_T    <= 1'b1;
      PAD_O    <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      state    <= state_nxt;
      div_cnt  <= div_nxt;
      bit_cnt  <= bit_nxt;
      shreg    <= sh_nxt;
      rd       <= rd_nxt;
      PAD_T    <= (state_nxt != ST_DRIVE);
      PAD_O    <= (state_nxt == ST_DRIVE) && sh_nxt[WIDTH-1];
      rx_valid <= rx_fire;
      if (rx_fire) begin
        rx_data <= sh_nxt;
      end
    end
  end

  assign tx_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_half_duplex_pad_ctrl.sv
// tb_half_duplex_pad_ctrl: bench for half_duplex_pad_ctrl in two configurations (8/4/2 and 1/1/1).
// A frame-level model predicts the per-cycle pad pattern, tx_ready/busy and the reply of each accepted request;
// a monitor pops those expectations as the DUT presents busy cycles and rx_valid pulses.
module tb_half_duplex_pad_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit fin [2];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input string why);
    total++;
    bad++;
    $display("FAIL %s: %s at %0t", name, why, $time);
  endtask

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int W     = (g == 0) ? 8 : 1;
    localparam int D     = (g == 0) ? 4 : 1;
    localparam int T     = (g == 0) ? 2 : 1;
    localparam int NRAND = (g == 0) ? 30 : 40;

    logic         rst, tx_valid, tx_ready, tx_read, rx_valid, pad_o, pad_t, pad_i, busy;
    logic [W-1:0] tx_data, rx_data;

    half_duplex_pad_ctrl #(.WIDTH(W), .DIV(D), .TURN(T)) dut (
      .CLK      (clk),
      .RST      (rst),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .tx_data  (tx_data),
      .tx_read  (tx_read),
      .rx_valid (rx_valid),
      .rx_data  (rx_data),
      .PAD_O    (pad_o),
      .PAD_T    (pad_t),
      .PAD_I    (pad_i),
      .busy     (busy)
    );

    // Model state: expected {PAD_T, PAD_O} for each busy cycle, and expected replies.
    logic [1:0]   pad_q [$];
    logic [W-1:0] rxd_q [$];
    int           rxc_q [$];
    int           mcyc      = 0;
    int           busy_left = 0;
    int           acc_cnt   = 0;
    int           acc_cyc   = 0;
    bit           cur_read  = 0;
    logic [W-1:0] cur_resp  = '0;
    logic [W-1:0] resp_next = '0;
    logic [W-1:0] held_rx   = '0;

    always @(posedge clk) begin : model
      int len;
      mcyc++;
      if (rst) begin
        pad_q.delete();
        rxd_q.delete();
        rxc_q.delete();
        busy_left = 0;
        held_rx   = '0;
      end else if (tx_valid && busy_left == 0) begin
        len = W * D + T + (tx_read ? (W - 1) * D + D / 2 + 1 : 0);
        for (int i = 0; i < W * D; i++) pad_q.push_back({1'b0, tx_data[W-1-i/D]});
        for (int i = W * D; i < len; i++) pad_q.push_back(2'b10);
        if (tx_read) begin
          rxd_q.push_back(resp_next);
          rxc_q.push_back(mcyc + len);
        end
        cur_resp  = resp_next;
        cur_read  = tx_read;
        acc_cyc   = mcyc;
        busy_left = len;
        acc_cnt++;
      end else if (busy_left > 0) begin
        busy_left--;
      end
    end

    // Pad input: reply bits held for a whole bit period during sampling, noise elsewhere.
    always @(posedge clk) begin : pad_drv
      int k, j;
      #1;
      k = mcyc - acc_cyc + 1;
      j = k - W * D - T - 1;
      if (cur_read && busy_left > 0 && j >= 0) pad_i = cur_resp[W-1-j/D];
      else pad_i = 1'($urandom);
    end

    always @(negedge clk) begin : mon
      logic [1:0] e;
      if (mcyc > 0) begin
        check("tx_ready", tx_ready, busy_left == 0);
        check("busy", busy, busy_left != 0);
        if (busy) begin
          if (pad_q.size() == 0) begin
            fail_now("pad_seq", "got busy=1 want idle (no expected pad cycle)");
          end else begin
            e = pad_q.pop_front();
            check("pad_t", pad_t, e[1]);
            check("pad_o", pad_o, e[0]);
          end
        end else begin
          check("idle_pad_t", pad_t, 1);
          check("idle_pad_o", pad_o, 0);
        end
        if (rx_valid) begin
          check("rx_cycle_ready", tx_ready, 1);
          if (rxd_q.size() == 0) begin
            fail_now("rx_unexpected", "got rx_valid=1 want 0");
          end else begin
            held_rx = rxd_q.pop_front();
            check("rx_data", rx_data, held_rx);
            check("rx_cycle", mcyc, rxc_q.pop_front());
          end
        end else begin
          check("rx_hold", rx_data, held_rx);
          if (rxc_q.size() != 0 && rxc_q[0] <= mcyc) begin
            fail_now("rx_missing", "got rx_valid=0 want 1");
            void'(rxd_q.pop_front());
            void'(rxc_q.pop_front());
          end
        end
      end
    end

    task automatic wait_accept(input int prev, input string nm);
      int n = 0;
      while (acc_cnt == prev && n < 400) begin
        @(posedge clk);
        #1;
        n++;
      end
      if (acc_cnt == prev) fail_now(nm, "got no acceptance want acceptance");
    endtask

    task automatic wait_idle(input string nm);
      int n = 0;
      while (busy_left != 0 && n < 1000) begin
        @(posedge clk);
        #1;
        n++;
      end
      if (busy_left != 0) fail_now(nm, "got still busy want idle");
    endtask

    task automatic send(input logic [W-1:0] d, input bit rd, input logic [W-1:0] resp, input bit noisy);
      int prev = acc_cnt;
      tx_valid  = 1'b1;
      tx_data   = d;
      tx_read   = rd;
      resp_next = resp;
      wait_accept(prev, "accept");
      tx_valid = 1'b0;
      if (noisy) begin
        while (busy_left > 1) begin
          tx_valid  = 1'($urandom);
          tx_data   = W'($urandom);
          tx_read   = 1'($urandom);
          resp_next = W'($urandom);
          @(posedge clk);
          #1;
        end
        tx_valid = 1'b0;
      end
      wait_idle("frame_end");
    endtask

    initial begin : stim
      int prev;
      rst      = 1'b1;
      tx_valid = 1'b0;
      tx_read  = 1'b0;
      tx_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_tx_ready", tx_ready, 1);
      check("rst_pad_t", pad_t, 1);
      check("rst_pad_o", pad_o, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_rx_data", rx_data, 0);
      check("rst_busy", busy, 0);

      // Plain write, then read with a fixed reply.
      send(W'(8'hA5), 1'b0, '0, 1'b0);
      send(W'(8'h01), 1'b1, W'(8'h3C), 1'b0);

      // Reset in the 10th cycle after acceptance: the read must be abandoned.
      prev      = acc_cnt;
      tx_valid  = 1'b1;
      tx_data   = W'(8'hC3);
      tx_read   = 1'b1;
      resp_next = W'(8'h5A);
      wait_accept(prev, "rst_accept");
      tx_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("abort_pad_t", pad_t, 1);
      check("abort_tx_ready", tx_ready, 1);
      repeat (2) @(posedge clk);
      #1;
      send(W'(8'h96), 1'b1, W'(8'h69), 1'b0);

      // Back-to-back reads with tx_valid held high across the rx_valid cycle.
      prev      = acc_cnt;
      tx_valid  = 1'b1;
      tx_data   = W'(8'h81);
      tx_read   = 1'b1;
      resp_next = W'(8'hE7);
      wait_accept(prev, "b2b_first");
      tx_data   = W'(8'h7E);
      resp_next = W'(8'h18);
      prev      = acc_cnt;
      wait_accept(prev, "b2b_second");
      tx_valid = 1'b0;
      wait_idle("b2b_end");

      // Requests toggling during a read and during a write must be ignored.
      send(W'(8'h4B), 1'b1, W'(8'hD2), 1'b1);
      send(W'(8'hB4), 1'b0, '0, 1'b1);

      for (int i = 0; i < NRAND; i++) begin
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk);
          #1;
        end
        send(W'($urandom), 1'($urandom), W'($urandom), 1'($urandom));
      end

      repeat (3) @(posedge clk);
      #1;
      check("pad_q_left", pad_q.size(), 0);
      check("rx_q_left", rxd_q.size(), 0);
      fin[g] = 1'b1;
    end
  end

  initial begin : finish_blk
    int n = 0;
    while (!(fin[0] && fin[1]) && n < 50000) begin
      @(posedge clk);
      n++;
    end
    if (!(fin[0] && fin[1])) fail_now("run_timeout", "got unfinished stimulus want finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
